mod_counter: RTL
================

# mod_counter

Parametrised universal counter, the successor to the team's free-running binary counter with start-value load. It adds a runtime-programmable terminal value, up/down direction, count enable, synchronous clear, and three end-of-range modes: wrap, saturate, and one-shot. It also provides a registered terminal-count pulse and a done flag. It serves as the timebase and event counter for timers, prescalers and sequencers elsewhere in the design.

## Interface
- N, 8, counter width in bits (N >= 2)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  count enable; one step per cycle while high
- clr  in  1  synchronous clear
- load  in  1  synchronous load of load_val
- load_val  in  N  value to load
- up  in  1  direction: 1 = increment, 0 = decrement
- mod_max  in  N  terminal value; legal count range is 0..mod_max
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
- q  out  N  registered count
- tc  out  1  registered one-cycle terminal-count pulse
- done  out  1  high while the FSM is in DONE (one-shot only)

## Operation
- The terminal value depends on direction: up = mod_max, down = 0.
- Priority per cycle: reset > clr > load > en.
- **clr:** q <= 0; FSM -> RUN.
- **load:** q <= min(load_val, mod_max); FSM -> RUN. Loading does not count as a step.
- **FSM states:** RUN and DONE.
  - RUN: an enabled step is taken as defined below.
  - DONE: en is ignored and q holds. Exit to RUN only via clr or load.
- **Enabled step in RUN, up, q < mod_max:** q+1.
- **Enabled step in RUN, down, q > 0:** q-1.
- **At terminal, up (q >= mod_max):**
  - wrap: q <= 0.
  - saturate: q <= mod_max.
  - one-shot: q <= mod_max; FSM -> DONE.
- **At terminal, down (q == 0):**
  - wrap: q <= mod_max.
  - saturate: q <= 0.
  - one-shot: q <= 0; FSM -> DONE.
- **One-shot entry to DONE:** FSM -> DONE on the same edge at which q becomes the terminal value by stepping, or at the first enabled step attempted while q is already at the terminal value.
- **mod_max lowered below q mid-count:**
  - up: the next enabled step is treated as at terminal (wrap -> 0; saturate/one-shot -> mod_max).
  - down: decrement normally.
- **mod_max = 0:** q is always 0. In wrap mode, tc pulses on every enabled cycle.
- **Direction change:** takes effect on the next step. In saturate mode q may leave the limit in the opposite direction.
- **tc:** high for exactly the one cycle following any edge at which q was set to the terminal value by a step (wrap included: up-wrap to 0 does not pulse; up reaching mod_max does). Load and clr never raise tc. In saturate mode, holding at the limit does not re-pulse.
- **Arithmetic:** unsigned, N bits. Results never leave 0..mod_max except when mod_max is lowered below q (see above).

## Timing
- **Reset values:** q = 0, tc = 0, done = 0, FSM = RUN.
- **Reset assertion:** asynchronous, effective immediately. Reset mid-count discards all state.
- **Reset release:** synchronous to clk.
- **Latency:** en/clr/load sampled at edge k appear on q after edge k; tc and done update on the same edge as q.
- **Combinational paths:** none from inputs to outputs. All outputs are registered.
- **Simultaneous clr and load:** clr wins.
- **Simultaneous load and en:** load wins; no step is taken.

## Structure
- Shared package holds:
  - mode encodings MODE_WRAP, MODE_SAT, MODE_ONESHOT;
  - the FSM state enum ST_RUN, ST_DONE.
- One natural sub-module, mod_counter_next: combinational next-q / at-terminal / next-state logic. The top module holds the state registers, tc and done.
- Register, next-state and output logic stay in separate processes.

## Test plan
- N=8, mod_max=5, mode=wrap, up, en=1 for 8 cycles after reset -> q = 1,2,3,4,5,0,1,2; tc high only in the cycle q=5.
- mod_max=5, mode=saturate, load 3, down, en=1 for 5 cycles -> q = 2,1,0,0,0; tc once (q=0 cycle); then up=1 for 1 cycle -> q=1.
- mode=one-shot, mod_max=3, clr then en=1 for 6 cycles -> q = 1,2,3,3,3,3; done rises with q=3 and stays; load 0 -> done=0, counting resumes.
- load_val=200 with mod_max=10 -> q=10, tc=0; same cycle clr=1 and load=1 -> q=0.
- Wrap mode, up, q=9: change mod_max 10 -> 4, en=1 -> q=0. Separately, en=1 with reset pulsed mid-count -> q=0 immediately, tc=0, done=0.

Source files
------------

// File: rtl/mod_counter_pkg.sv
// Shared encodings for the universal counter: end-of-range modes and FSM states.
package mod_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10
  } mode_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

endpackage : mod_counter_pkg

// File: rtl/mod_counter_if.sv
// Control/status bundle of the universal counter; master drives controls, slave is the counter.
interface mod_counter_if #(
  parameter int N = 8
);

  logic         en;
  logic         clr;
  logic         load;
  logic [N-1:0] load_val;
  logic         up;
  logic [N-1:0] mod_max;
  logic [1:0]   mode;
  logic [N-1:0] q;
  logic         tc;
  logic         done;

  modport master (
    output en, clr, load, load_val, up, mod_max, mode,
    input  q, tc, done
  );

  modport slave (
    input  en, clr, load, load_val, up, mod_max, mode,
    output q, tc, done
  );

endinterface : mod_counter_if

// File: rtl/mod_counter_next.sv
// Combinational next-count, terminal-count and next-state logic of the universal counter.
module mod_counter_next
  import mod_counter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] q,
  input  state_t       state,
  input  logic         en,
  input  logic         clr,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         up,
  input  logic [N-1:0] mod_max,
  input  logic [1:0]   mode,
  output logic [N-1:0] q_next,
  output state_t       state_next,
  output logic         tc_next
);

  localparam logic [N-1:0] ZERO = {N{1'b0}};
  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] term_s;
  logic         at_term_s;
  logic         is_sat_s;
  logic         is_oneshot_s;

  function automatic logic [N-1:0] clamp(input logic [N-1:0] v, input logic [N-1:0] lim);
    if (v > lim) begin
      return lim;
    end else begin
      return v;
    end
  endfunction

  // q above a lowered mod_max counts as terminal when counting up
  assign term_s    = up ? mod_max : ZERO;
  assign at_term_s = up ? (q >= mod_max) : (q == ZERO);

  // Decode end-of-range mode; the reserved encoding behaves as wrap
  always_comb begin
    is_sat_s     = 1'b0;
    is_oneshot_s = 1'b0;
    case (mode)
      MODE_WRAP:    begin is_sat_s = 1'b0; is_oneshot_s = 1'b0; end
      MODE_SAT:     begin is_sat_s = 1'b1; is_oneshot_s = 1'b0; end
      MODE_ONESHOT: begin is_sat_s = 1'b0; is_oneshot_s = 1'b1; end
      default:      begin is_sat_s = 1'b0; is_oneshot_s = 1'b0; end
    endcase
  end

  // Priority clr > load > enabled step; DONE ignores en
  always_comb begin
    q_next     = q;
    state_next = state;
    tc_next    = 1'b0;
    if (clr) begin
      q_next     = ZERO;
      state_next = ST_RUN;
    end else if (load) begin
      q_next     = clamp(load_val, mod_max);
      state_next = ST_RUN;
    end else if (en && (state == ST_RUN)) begin
      if (at_term_s) begin
        if (is_sat_s || is_oneshot_s) begin
          q_next = term_s;
        end else begin
          q_next = up ? ZERO : mod_max;
        end
      end else begin
        q_next = up ? (q + ONE) : (q - ONE);
      end
      // Holding at the limit is not a fresh arrival, so it does not pulse
      if (q_next == term_s) begin
        tc_next = (is_sat_s || is_oneshot_s) ? (q_next != q) : 1'b1;
        if (is_oneshot_s) begin
          state_next = ST_DONE;
        end else begin
          state_next = state;
        end
      end else begin
        tc_next = 1'b0;
      end
    end else begin
      q_next = q;
    end
  end

endmodule : mod_counter_next

// File: rtl/mod_counter.sv
// Universal modulo counter: wrap / saturate / one-shot, up/down, with registered tc and done.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic        clk,
  input  logic        reset,
  mod_counter_if.slave bus
);

  logic [N-1:0] q_r;
  state_t       state_r;
  logic         tc_r;
  logic         done_r;

  logic [N-1:0] q_next_s;
  state_t       state_next_s;
  logic         tc_next_s;

  mod_counter_next #(
    .N(N)
  ) u_next (
    .q          (q_r),
    .state      (state_r),
    .en         (bus.en),
    .clr        (bus.clr),
    .load       (bus.load),
    .load_val   (bus.load_val),
    .up         (bus.up),
    .mod_max    (bus.mod_max),
    .mode       (bus.mode),
    .q_next     (q_next_s),
    .state_next (state_next_s),
    .tc_next    (tc_next_s)
  );

  // Count, FSM state and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r     <= {N{1'b0}};
      state_r <= ST_RUN;
      tc_r    <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      q_r     <= q_next_s;
      state_r <= state_next_s;
      tc_r    <= tc_next_s;
      done_r  <= (state_next_s == ST_DONE);
    end
  end

  assign bus.q    = q_r;
  assign bus.tc   = tc_r;
  assign bus.done = done_r;

endmodule : mod_counter
